// File: rtl/i2s_sample_feeder.sv
// Sample FIFO plus request/ack responder feeding the I2S serial writer.
// Optional: define I2S_FEEDER_MUTE_EN to answer empty-FIFO requests with silence.
module i2s_sample_feeder #(
    parameter int unsigned DATA_SIZE       = 24,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_wr_stb,
    input  logic [DATA_SIZE-1:0]       sample_wr_data,
    input  logic                       sample_wr_lr,
    output logic                       sample_full,
    output logic                       sample_empty,
    output logic [FIFO_DEPTH_LOG2:0]   sample_count,
    input  logic                       audio_data_request,
    output logic                       audio_data_ack,
    output logic [DATA_SIZE-1:0]       audio_data,
    output logic                       audio_lr_bit,
    output logic                       underflow,
    output logic                       overflow,
    input  logic                       status_clear
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    logic [DATA_SIZE:0] mem_q [DEPTH];
    logic [DATA_SIZE:0] head;

    state_t               state_q, state_d;
    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    cnt_t                 count_q, count_d;
    logic                 ack_q, ack_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 lr_q, lr_d;
    logic                 underflow_q, underflow_d;
    logic                 overflow_q, overflow_d;
    logic                 pop, push_ok, uf_set, of_set;
    logic                 full, empty;
`ifdef I2S_FEEDER_MUTE_EN
    logic                 last_lr_q, last_lr_d;
`endif

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        data_d  = data_q;
        lr_d    = lr_q;
        pop     = 1'b0;
        uf_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && audio_data_request) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        ack_d   = 1'b1;
                        data_d  = head[DATA_SIZE-1:0];
                        lr_d    = head[DATA_SIZE];
                        state_d = ACK;
                    end else begin
                        uf_set  = 1'b1;
`ifdef I2S_FEEDER_MUTE_EN
                        ack_d   = 1'b1;
                        data_d  = '0;
                        lr_d    = ~last_lr_q;
                        state_d = ACK;
`endif
                    end
                end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!audio_data_request) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    always_comb begin
        push_ok  = sample_wr_stb && (!full || pop);
        of_set   = sample_wr_stb && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + cnt_t'(1);
        else if (pop && !push_ok) count_d = count_q - cnt_t'(1);
        underflow_d = uf_set || (underflow_q && !status_clear);
        overflow_d  = of_set || (overflow_q && !status_clear);
`ifdef I2S_FEEDER_MUTE_EN
        last_lr_d   = ack_d ? lr_d : last_lr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            data_q      <= '0;
            lr_q        <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef I2S_FEEDER_MUTE_EN
            last_lr_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            data_q      <= data_d;
            lr_q        <= lr_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
`ifdef I2S_FEEDER_MUTE_EN
            last_lr_q   <= last_lr_d;
`endif
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {sample_wr_lr, sample_wr_data};
    end

    assign sample_full    = full;
    assign sample_empty   = empty;
    assign sample_count   = count_q;
    assign audio_data_ack = ack_q;
    assign audio_data     = data_q;
    assign audio_lr_bit   = lr_q;
    assign underflow      = underflow_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: driver queues expected samples, monitor checks each ack.
module tb_i2s_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_wr_stb;
    logic [23:0] sample_wr_data;
    logic        sample_wr_lr;
    logic        sample_full;
    logic        sample_empty;
    logic [4:0]  sample_count;
    logic        audio_data_request;
    logic        audio_data_ack;
    logic [23:0] audio_data;
    logic        audio_lr_bit;
    logic        underflow;
    logic        overflow;
    logic        status_clear;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_ack = -1;
    logic [24:0] exp_q [$];

    i2s_sample_feeder #(.DATA_SIZE(24), .FIFO_DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_wr_stb(sample_wr_stb), .sample_wr_data(sample_wr_data), .sample_wr_lr(sample_wr_lr),
        .sample_full(sample_full), .sample_empty(sample_empty), .sample_count(sample_count),
        .audio_data_request(audio_data_request), .audio_data_ack(audio_data_ack),
        .audio_data(audio_data), .audio_lr_bit(audio_lr_bit),
        .underflow(underflow), .overflow(overflow), .status_clear(status_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack must match the oldest expected sample and be >=3 cycles after the last.
    always @(negedge clk) begin
        if (rst === 1'b1 && audio_data_ack === 1'b1) begin
            logic [24:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ack: got data=%h lr=%b, required no ack", audio_data, audio_lr_bit);
            end else begin
                e = exp_q.pop_front();
                if ({audio_lr_bit, audio_data} !== e) begin
                    miscompares++;
                    $display("FAIL ack_data: got lr=%b data=%h, required lr=%b data=%h",
                             audio_lr_bit, audio_data, e[24], e[23:0]);
                end
            end
            if (last_ack >= 0) begin
                vectors++;
                if (cyc - last_ack < 3) begin
                    miscompares++;
                    $display("FAIL ack_spacing: got %0d cycles, required >= 3", cyc - last_ack);
                end
            end
            last_ack = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic lr, input bit expect_out);
        sample_wr_stb  = 1'b1;
        sample_wr_data = d;
        sample_wr_lr   = lr;
        if (expect_out) exp_q.push_back({lr, d});
        @(negedge clk);
        sample_wr_stb  = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (audio_data_ack === 1'b1) begin
                got = 1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL ack_timeout: got no ack in %0d cycles, required an ack", budget);
        end
    endtask

    // Writer model: raise request, drop it one edge after the ack, let the FSM return to IDLE.
    task automatic serve(input int budget);
        audio_data_request = 1'b1;
        wait_ack(budget);
        audio_data_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic clear_pulse();
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; sample_wr_stb = 1'b0; sample_wr_data = '0;
        sample_wr_lr = 1'b0; audio_data_request = 1'b1; status_clear = 1'b0;

        // Reset held with request and strobes active
        repeat (2) @(negedge clk);
        push(24'h123456, 1'b1, 1'b0);
        push(24'h654321, 1'b0, 1'b0);
        chk("rst_ack", 32'(audio_data_ack), 32'h0);
        chk("rst_count", 32'(sample_count), 32'h0);
        chk("rst_empty", 32'(sample_empty), 32'h1);
        chk("rst_full", 32'(sample_full), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_data", {7'h0, audio_lr_bit, audio_data}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("disabled_underflow", 32'(underflow), 32'h0);
        chk("post_rst_count", 32'(sample_count), 32'h0);
        audio_data_request = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Single sample, request held afterwards
        push(24'hABCDEF, 1'b1, 1'b1);
        audio_data_request = 1'b1;
        wait_ack(8);
        repeat (5) @(negedge clk);
        chk("single_count", 32'(sample_count), 32'h0);
        chk("single_empty", 32'(sample_empty), 32'h1);
        audio_data_request = 1'b0;
        repeat (2) @(negedge clk);

        // Underflow
`ifdef I2S_FEEDER_MUTE_EN
        exp_q.push_back({1'b0, 24'h0});
        serve(8);
        chk("underflow_set", 32'(underflow), 32'h1);
`else
        audio_data_request = 1'b1;
        repeat (4) @(negedge clk);
        chk("underflow_set", 32'(underflow), 32'h1);
        clear_pulse();
        chk("underflow_set_wins", 32'(underflow), 32'h1);
        audio_data_request = 1'b0;
        @(negedge clk);
`endif
        clear_pulse();
        chk("underflow_clear", 32'(underflow), 32'h0);

        // Fill to 16, 17th push overflows (set beats a concurrent clear)
        for (int i = 1; i <= 16; i++) begin
            logic [23:0] v = 24'(i);
            push(v, v[0], 1'b1);
        end
        status_clear = 1'b1;
        push(24'h000011, 1'b1, 1'b0);
        status_clear = 1'b0;
        chk("fill_full", 32'(sample_full), 32'h1);
        chk("fill_count", 32'(sample_count), 32'h10);
        chk("fill_overflow", 32'(overflow), 32'h1);
        chk("fill_empty", 32'(sample_empty), 32'h0);
        clear_pulse();
        chk("overflow_clear", 32'(overflow), 32'h0);

        // Push in the same cycle as a pop while full
        audio_data_request = 1'b1;
        sample_wr_stb = 1'b1; sample_wr_data = 24'h000012; sample_wr_lr = 1'b0;
        exp_q.push_back({1'b0, 24'h000012});
        @(negedge clk);
        sample_wr_stb = 1'b0;
        audio_data_request = 1'b0;
        chk("pp_ack", 32'(audio_data_ack), 32'h1);
        chk("pp_count", 32'(sample_count), 32'h10);
        chk("pp_full", 32'(sample_full), 32'h1);
        chk("pp_overflow", 32'(overflow), 32'h0);
        repeat (2) @(negedge clk);
        repeat (16) serve(8);
        chk("drain_count", 32'(sample_count), 32'h0);
        chk("drain_empty", 32'(sample_empty), 32'h1);

        // Back-to-back handshakes
        push(24'hA00001, 1'b0, 1'b1);
        push(24'hA00002, 1'b1, 1'b1);
        push(24'hA00003, 1'b0, 1'b1);
        push(24'hA00004, 1'b1, 1'b1);
        chk("b2b_count", 32'(sample_count), 32'h4);
        repeat (4) serve(8);

        // Enable dropped mid-handshake; no ack while disabled
        push(24'h5A5A5A, 1'b1, 1'b1);
        push(24'h3C3C3C, 1'b0, 1'b1);
        audio_data_request = 1'b1;
        wait_ack(8);
        enable = 1'b0;
        audio_data_request = 1'b0;
        repeat (2) @(negedge clk);
        audio_data_request = 1'b1;
        repeat (4) @(negedge clk);
        chk("disabled_count", 32'(sample_count), 32'h1);
        chk("disabled_no_underflow", 32'(underflow), 32'h0);
        enable = 1'b1;
        wait_ack(8);
        audio_data_request = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-handshake discards the FIFO
        push(24'h777777, 1'b1, 1'b1);
        push(24'h888888, 1'b0, 1'b0);
        audio_data_request = 1'b1;
        wait_ack(8);
        #1 rst = 1'b0;
        audio_data_request = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 32'(audio_data_ack), 32'h0);
        chk("midrst_count", 32'(sample_count), 32'h0);
        chk("midrst_empty", 32'(sample_empty), 32'h1);
        chk("midrst_data", 32'(audio_data), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
